// File: rtl/rescale_job_ctrl.sv
// Rescale job sequencer: walks destination pixels in raster order, maps each to its
// source ROM address for the latched mode and writes the frame buffer, yielding to the display reader.
module rescale_job_ctrl #(
    parameter int unsigned SRC_W  = 160,
    parameter int unsigned SRC_H  = 120,
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned PIX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              vga_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  pixel_rom,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]  fb_data,
    output logic              busy,
    output logic              done
);
    localparam int unsigned X_W = $clog2(4 * SRC_W);
    localparam int unsigned Y_W = $clog2(4 * SRC_H);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [ADDR_W-1:0] dst_q;
    logic              p_valid_q;
    logic [ADDR_W-1:0] p_dst_q;
    logic [ADDR_W-1:0] p_src_q;

    logic [X_W-1:0]    last_x;
    logic [Y_W-1:0]    last_y;
    logic [ADDR_W-1:0] src_row;
    logic [ADDR_W-1:0] src_col;
    logic [ADDR_W-1:0] src_addr;
    logic              issue;
    logic              last_pix;
    logic              write;

    // Destination extent and source coordinates for the latched mode
    always_comb begin
        last_x  = X_W'(SRC_W - 1);
        last_y  = Y_W'(SRC_H - 1);
        src_row = ADDR_W'(y_q);
        src_col = ADDR_W'(x_q);
        case (mode_q)
            2'b00: begin
                last_x  = X_W'(SRC_W - 1);
                last_y  = Y_W'(SRC_H - 1);
                src_row = ADDR_W'(y_q);
                src_col = ADDR_W'(x_q);
            end
            2'b01: begin
                last_x  = X_W'(2 * SRC_W - 1);
                last_y  = Y_W'(2 * SRC_H - 1);
                src_row = ADDR_W'(y_q >> 1);
                src_col = ADDR_W'(x_q >> 1);
            end
            2'b10: begin
                last_x  = X_W'(4 * SRC_W - 1);
                last_y  = Y_W'(4 * SRC_H - 1);
                src_row = ADDR_W'(y_q >> 2);
                src_col = ADDR_W'(x_q >> 2);
            end
            2'b11: begin
                last_x  = X_W'(SRC_W / 2 - 1);
                last_y  = Y_W'(SRC_H / 2 - 1);
                src_row = ADDR_W'(y_q) << 1;
                src_col = ADDR_W'(x_q) << 1;
            end
        endcase
    end

    assign src_addr = src_row * ADDR_W'(SRC_W) + src_col;
    assign issue    = (state_q == S_RUN) && !vga_req;
    assign last_pix = (x_q == last_x) && (y_q == last_y);
    assign write    = p_valid_q && !vga_req;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and state-decoded outputs; a stall re-presents the pending source address
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        fb_we    = 1'b0;
        rom_addr = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                busy     = 1'b1;
                fb_we    = write;
                rom_addr = vga_req ? p_src_q : src_addr;
                if (issue && last_pix) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                busy     = 1'b1;
                fb_we    = write;
                rom_addr = p_src_q;
                if (write || !p_valid_q) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign fb_addr = p_dst_q;
    assign fb_data = pixel_rom;

    // Mode latch, destination counters and one-deep write pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= 2'b00;
            x_q       <= '0;
            y_q       <= '0;
            dst_q     <= '0;
            p_valid_q <= 1'b0;
            p_dst_q   <= '0;
            p_src_q   <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                mode_q <= mode;
                x_q    <= '0;
                y_q    <= '0;
                dst_q  <= '0;
            end else if (issue) begin
                dst_q <= dst_q + ADDR_W'(1);
                if (x_q == last_x) begin
                    x_q <= '0;
                    y_q <= y_q + Y_W'(1);
                end else begin
                    x_q <= x_q + X_W'(1);
                end
            end
            if (issue) begin
                p_valid_q <= 1'b1;
                p_dst_q   <= dst_q;
                p_src_q   <= src_addr;
            end else if (write) begin
                p_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rescale_job_ctrl.sv
// Randomized bench for rescale_job_ctrl: reduced image size, ROM model, and a pixel-index
// reference model deriving every write and cycle count from the rescale rules.
module tb_rescale_job_ctrl;
    localparam int SW = 16;
    localparam int SH = 10;
    localparam int AW = 12;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic          vga_req;
    logic [AW-1:0] rom_addr;
    logic [PW-1:0] pixel_rom;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [PW-1:0] fb_data;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    rescale_job_ctrl #(.SRC_W(SW), .SRC_H(SH), .ADDR_W(AW), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .vga_req(vga_req),
        .rom_addr(rom_addr), .pixel_rom(pixel_rom), .fb_we(fb_we), .fb_addr(fb_addr),
        .fb_data(fb_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] rom_f(input int a);
        return PW'((a * 13) ^ (a >> 5));
    endfunction

    // Synchronous source ROM
    always @(posedge clk) pixel_rom <= rom_f(int'(rom_addr));

    function automatic int dest_w(input logic [1:0] m);
        case (m)
            2'b00: return SW;
            2'b01: return 2 * SW;
            2'b10: return 4 * SW;
            default: return SW / 2;
        endcase
    endfunction

    function automatic int dest_h(input logic [1:0] m);
        case (m)
            2'b00: return SH;
            2'b01: return 2 * SH;
            2'b10: return 4 * SH;
            default: return SH / 2;
        endcase
    endfunction

    // Source pixel for destination index k
    function automatic int src_of(input logic [1:0] m, input int k);
        int dw, y, x;
        dw = dest_w(m);
        y = k / dw;
        x = k % dw;
        case (m)
            2'b00: return y * SW + x;
            2'b01: return (y / 2) * SW + x / 2;
            2'b10: return (y / 4) * SW + x / 4;
            default: return (2 * y) * SW + 2 * x;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_we"}, 32'(fb_we), 32'd0);
        check_eq({tag, "_rom"}, 32'(rom_addr), 32'd0);
    endtask

    // stall_mode: 0 none, 1 random, 2 three cycles after the 10th write
    task automatic run_job(input logic [1:0] m, input int stall_mode, input bit disturb,
                           input int rst_at);
        int n, ns, stalls, stall_left, wk, c;
        bit fin, aborted;
        n = dest_w(m) * dest_h(m);
        ns = 0; stalls = 0; stall_left = 0; fin = 0; aborted = 0;
        @(negedge clk);
        start = 1'b1; mode = m; vga_req = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (c = 1; c <= 3 * n + 50 && !fin; c++) begin
            if (disturb && (c % 37 == 0)) begin
                start = 1'b1;
                mode = 2'($urandom);
            end else begin
                start = 1'b0;
            end
            case (stall_mode)
                1: vga_req = ($urandom_range(0, 3) == 0);
                2: begin
                    vga_req = (stall_left > 0);
                    if (stall_left > 0) stall_left--;
                end
                default: vga_req = 1'b0;
            endcase
            @(negedge clk);
            if (ns == n + 1) begin
                check_eq("done", 32'(done), 32'd1);
                check_eq("done_busy", 32'(busy), 32'd0);
                check_eq("done_we", 32'(fb_we), 32'd0);
                check_eq("done_rom", 32'(rom_addr), 32'd0);
                check_eq("done_cycle", 32'(c), 32'(n + 2 + stalls));
                fin = 1;
            end else begin
                check_eq("busy", 32'(busy), 32'd1);
                check_eq("done_early", 32'(done), 32'd0);
                if (vga_req) begin
                    stalls++;
                    check_eq("stall_we", 32'(fb_we), 32'd0);
                    if (ns >= 1) check_eq("stall_rom", 32'(rom_addr), 32'(src_of(m, ns - 1)));
                end else begin
                    if (ns < n) check_eq("issue_rom", 32'(rom_addr), 32'(src_of(m, ns)));
                    if (ns >= 1) begin
                        wk = ns - 1;
                        check_eq("we", 32'(fb_we), 32'd1);
                        check_eq("fb_addr", 32'(fb_addr), 32'(wk));
                        check_eq("fb_data", 32'(fb_data), 32'(rom_f(src_of(m, wk))));
                        if (stall_mode == 2 && wk == 9) stall_left = 3;
                    end else begin
                        check_eq("first_we", 32'(fb_we), 32'd0);
                    end
                    ns++;
                    if (rst_at >= 0 && ns - 1 == rst_at + 1) begin
                        rst = 1'b1;
                        #1;
                        check_idle_outputs("rst_now");
                        check_eq("rst_fb_addr", 32'(fb_addr), 32'd0);
                        repeat (3) begin
                            @(negedge clk);
                            check_eq("rst_hold_we", 32'(fb_we), 32'd0);
                        end
                        rst = 1'b0;
                        aborted = 1;
                        fin = 1;
                    end
                end
            end
            if (fin) begin
                start = 1'b0;
                vga_req = 1'b0;
            end
            @(posedge clk); #1;
        end
        if (!fin) check_eq("timeout", 32'd0, 32'd1);
        if (!aborted) begin
            @(negedge clk);
            check_idle_outputs("idle");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'b00; vga_req = 1'b0;
        #12;
        check_idle_outputs("reset");
        check_eq("reset_fb_addr", 32'(fb_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        run_job(2'b00, 0, 1'b0, -1);
        run_job(2'b01, 0, 1'b0, -1);
        run_job(2'b01, 2, 1'b0, -1);
        run_job(2'b10, 1, 1'b0, -1);
        run_job(2'b11, 0, 1'b0, -1);
        run_job(2'b11, 1, 1'b0, -1);
        run_job(2'b01, 1, 1'b1, -1);
        run_job(2'b01, 0, 1'b0, 500);
        run_job(2'b00, 1, 1'b0, -1);
        run_job(2'b10, 0, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
